// File: rtl/sdram_arbit_if.sv
// ----------------------------------------------------------------------------
// sdram_arbit_if
// Bundle of every signal between the SDRAM command-bus arbiter and the
// world around it: the init / auto-refresh / write / read sub-modules on one
// side and the SDRAM pins on the other.
//
// Handshake (one rule for all three requesters):
//   - A requester raises *_req and holds it until its *_en goes high.
//   - *_en is high for exactly as long as the requester owns the bus.
//   - The requester pulses *_end in the last cycle of its ownership; the
//     arbiter drops *_en after that edge and drives one NOP cycle before
//     the next owner can be granted.
//
// Modports:
//   slave  - arbiter side (requests/buses in, grants/pins out)
//   master - requester/pin side, used by whatever drives the arbiter
// ----------------------------------------------------------------------------
interface sdram_arbit_if;
    // init module
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;

    // auto-refresh module
    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        aref_en;

    // write module
    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_data;
    logic        wr_en;

    // read module
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        rd_en;

    // SDRAM pins
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbit.sv
// ----------------------------------------------------------------------------
// sdram_arbit
// Command-bus arbiter for the SDRAM controller. Grants the single
// command/address/DQ bus to one of refresh, write or read at a time.
// Priority is refresh > write > read, except that after RD_STARVE_MAX
// consecutive write grants taken while a read was waiting, read outranks
// write once.
//
// Ports:
//   clk            controller clock (single domain)
//   rstn           asynchronous active-low reset
//   bus            sdram_arbit_if.slave: requester buses, grants, SDRAM pins
//   dbg_state      current FSM state (IDLE=0, ARBIT=1, AREF=2, WRITE=3, READ=4)
//   dbg_starve_cnt current read-starvation counter
// ----------------------------------------------------------------------------
module sdram_arbit #(
    parameter int         RD_STARVE_MAX = 4,
    parameter logic [3:0] CMD_NOP       = 4'b0111
) (
    input  logic                clk,
    input  logic                rstn,
    sdram_arbit_if.slave        bus,
    output logic [2:0]          dbg_state,
    output logic [3:0]          dbg_starve_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(RD_STARVE_MAX);

    state_t      state;
    state_t      next_state;
    logic [3:0]  starve_cnt;

    logic [3:0]  mux_cmd;
    logic [1:0]  mux_ba;
    logic [12:0] mux_addr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.init_end) begin
                    next_state = ARBIT;
                end
            end
            ARBIT: begin
                // Starvation override only reorders write vs read; a
                // pending refresh still wins.
                if (bus.aref_req) begin
                    next_state = AREF;
                end else if (bus.rd_req && (starve_cnt == STARVE_MAX)) begin
                    next_state = READ;
                end else if (bus.wr_req) begin
                    next_state = WRITE;
                end else if (bus.rd_req) begin
                    next_state = READ;
                end
            end
            AREF: begin
                if (bus.aref_end) begin
                    next_state = ARBIT;
                end
            end
            WRITE: begin
                if (bus.wr_end) begin
                    next_state = ARBIT;
                end
            end
            READ: begin
                if (bus.rd_end) begin
                    next_state = ARBIT;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-starvation counter: counts write grants handed out while a read
    // was pending. It only moves on decisions taken in ARBIT, so it is
    // stable for the whole of every grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= 4'd0;
        end else if (state == ARBIT) begin
            if (!bus.rd_req) begin
                starve_cnt <= 4'd0;
            end else if (next_state == READ) begin
                starve_cnt <= 4'd0;
            end else if (next_state == WRITE) begin
                if (starve_cnt < STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Grants are decoded straight from the registered state so they drop
    // together with it on an asynchronous reset.
    // ------------------------------------------------------------------
    assign bus.aref_en = (state == AREF);
    assign bus.wr_en   = (state == WRITE);
    assign bus.rd_en   = (state == READ);

    // ------------------------------------------------------------------
    // Command / bank / address mux
    // ------------------------------------------------------------------
    always_comb begin
        mux_cmd  = bus.init_cmd;
        mux_ba   = bus.init_ba;
        mux_addr = bus.init_addr;
        case (state)
            IDLE: begin
                mux_cmd  = bus.init_cmd;
                mux_ba   = bus.init_ba;
                mux_addr = bus.init_addr;
            end
            ARBIT: begin
                mux_cmd  = CMD_NOP;
                mux_ba   = 2'b11;
                mux_addr = 13'h1fff;
            end
            AREF: begin
                mux_cmd  = bus.aref_cmd;
                mux_ba   = bus.aref_ba;
                mux_addr = bus.aref_addr;
            end
            WRITE: begin
                mux_cmd  = bus.wr_cmd;
                mux_ba   = bus.wr_ba;
                mux_addr = bus.wr_addr;
            end
            READ: begin
                mux_cmd  = bus.rd_cmd;
                mux_ba   = bus.rd_ba;
                mux_addr = bus.rd_addr;
            end
            default: begin
                mux_cmd  = bus.init_cmd;
                mux_ba   = bus.init_ba;
                mux_addr = bus.init_addr;
            end
        endcase
    end

    assign bus.sdram_cke   = 1'b1;
    assign bus.sdram_cs_n  = mux_cmd[3];
    assign bus.sdram_ras_n = mux_cmd[2];
    assign bus.sdram_cas_n = mux_cmd[1];
    assign bus.sdram_we_n  = mux_cmd[0];
    assign bus.sdram_ba    = mux_ba;
    assign bus.sdram_addr  = mux_addr;

    // DQ is only driven while the write module owns the bus and asks for
    // it; the output data is forced to zero otherwise to keep the pads quiet.
    assign bus.sdram_dq_oe  = bus.wr_sdram_en && (state == WRITE);
    assign bus.sdram_dq_out = bus.sdram_dq_oe ? bus.wr_data : 16'h0000;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_sdram_arbit.sv
// ----------------------------------------------------------------------------
// tb_sdram_arbit
// Directed bench for sdram_arbit: reset values, init hand-off, refresh
// priority, NOP gap between owners, DQ enable, stray end, asynchronous reset
// mid-read and the write/read starvation ordering.
// ----------------------------------------------------------------------------
module tb_sdram_arbit;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARBIT = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    logic       clk;
    logic       rstn;
    logic [2:0] dbg_state;
    logic [3:0] dbg_starve_cnt;

    int total;
    int bad;

    sdram_arbit_if bus ();

    sdram_arbit #(
        .RD_STARVE_MAX (4),
        .CMD_NOP       (4'b0111)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .bus            (bus),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pin_cmd();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
    endfunction

    function automatic logic [2:0] grants();
        return {bus.aref_en, bus.wr_en, bus.rd_en};
    endfunction

    // expected grant order with wr_req and rd_req held: W,W,W,W,R,W,W,W,W,R
    // encoded as {wr_en, rd_en}, plus the starve counter seen during each grant
    logic [1:0] exp_grant [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [3:0] exp_cnt   [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0,
                                   4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    initial begin
        logic got;
        total = 0;
        bad   = 0;

        // ---------------- reset ----------------
        rstn            = 1'b0;
        bus.init_end    = 1'b0;
        bus.init_cmd    = 4'b0010;
        bus.init_ba     = 2'b01;
        bus.init_addr   = 13'h0abc;
        bus.aref_req    = 1'b0;
        bus.aref_end    = 1'b0;
        bus.aref_cmd    = 4'b0001;
        bus.aref_ba     = 2'b10;
        bus.aref_addr   = 13'h0400;
        bus.wr_req      = 1'b0;
        bus.wr_end      = 1'b0;
        bus.wr_cmd      = 4'b0100;
        bus.wr_ba       = 2'b01;
        bus.wr_addr     = 13'h0123;
        bus.wr_sdram_en = 1'b0;
        bus.wr_data     = 16'hA5A5;
        bus.rd_req      = 1'b0;
        bus.rd_end      = 1'b0;
        bus.rd_cmd      = 4'b0101;
        bus.rd_ba       = 2'b11;
        bus.rd_addr     = 13'h0456;
        #1;
        check("rst_state",  32'(dbg_state), 32'(S_IDLE));
        check("rst_grants", 32'(grants()), 32'd0);
        check("rst_cnt",    32'(dbg_starve_cnt), 32'd0);
        check("rst_cke",    32'(bus.sdram_cke), 32'd1);
        check("rst_oe",     32'(bus.sdram_dq_oe), 32'd0);
        check("rst_dq",     32'(bus.sdram_dq_out), 32'd0);
        check("rst_cmd",    32'(pin_cmd()), 32'h2);

        tick();
        tick();
        rstn = 1'b1;

        // ---------------- init phase ----------------
        tick();
        tick();
        settle();
        check("idle_state", 32'(dbg_state), 32'(S_IDLE));
        check("idle_cmd",   32'(pin_cmd()), 32'h2);
        check("idle_ba",    32'(bus.sdram_ba), 32'h1);
        check("idle_addr",  32'(bus.sdram_addr), 32'h0abc);

        bus.init_end = 1'b1;
        tick();
        settle();
        check("arb_state",  32'(dbg_state), 32'(S_ARBIT));
        check("arb_cmd",    32'(pin_cmd()), 32'h7);
        check("arb_ba",     32'(bus.sdram_ba), 32'h3);
        check("arb_addr",   32'(bus.sdram_addr), 32'h1fff);
        check("arb_grants", 32'(grants()), 32'd0);

        // ---------------- refresh wins over everything ----------------
        bus.aref_req = 1'b1;
        bus.wr_req   = 1'b1;
        bus.rd_req   = 1'b1;
        tick();
        settle();
        check("aref_grants", 32'(grants()), 32'b100);
        check("aref_cmd",    32'(pin_cmd()), 32'h1);
        check("aref_addr",   32'(bus.sdram_addr), 32'h0400);
        check("aref_cnt",    32'(dbg_starve_cnt), 32'd0);

        bus.aref_req = 1'b0;
        bus.aref_end = 1'b1;
        tick();
        bus.aref_end = 1'b0;
        settle();
        check("nop_state",  32'(dbg_state), 32'(S_ARBIT));
        check("nop_cmd",    32'(pin_cmd()), 32'h7);
        check("nop_grants", 32'(grants()), 32'd0);

        tick();
        settle();
        check("wr_grants", 32'(grants()), 32'b010);
        check("wr_cmd",    32'(pin_cmd()), 32'h4);
        check("wr_addr",   32'(bus.sdram_addr), 32'h0123);
        check("wr_cnt",    32'(dbg_starve_cnt), 32'd1);

        // ---------------- DQ drive ----------------
        bus.wr_sdram_en = 1'b1;
        settle();
        check("dq_oe_on",  32'(bus.sdram_dq_oe), 32'd1);
        check("dq_out_on", 32'(bus.sdram_dq_out), 32'hA5A5);
        bus.wr_sdram_en = 1'b0;
        settle();
        check("dq_oe_off",  32'(bus.sdram_dq_oe), 32'd0);
        check("dq_out_off", 32'(bus.sdram_dq_out), 32'd0);

        // ---------------- stray rd_end in WRITE ----------------
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        settle();
        check("stray_state", 32'(dbg_state), 32'(S_WRITE));
        check("stray_wr_en", 32'(bus.wr_en), 32'd1);

        bus.wr_end = 1'b1;
        bus.wr_req = 1'b0;
        tick();
        bus.wr_end = 1'b0;
        settle();
        check("wr_end_state", 32'(dbg_state), 32'(S_ARBIT));

        // ---------------- read, then async reset in the middle ----------------
        tick();
        settle();
        check("rd_grants", 32'(grants()), 32'b001);
        check("rd_cnt",    32'(dbg_starve_cnt), 32'd0);
        check("rd_cmd",    32'(pin_cmd()), 32'h5);
        check("rd_ba",     32'(bus.sdram_ba), 32'h3);
        check("rd_addr",   32'(bus.sdram_addr), 32'h0456);

        #3;
        rstn = 1'b0;
        #1;
        check("arst_rd_en", 32'(bus.rd_en), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        check("arst_cmd",   32'(pin_cmd()), 32'h2);
        check("arst_addr",  32'(bus.sdram_addr), 32'h0abc);

        tick();
        rstn       = 1'b1;
        bus.wr_req = 1'b1;
        settle();
        check("post_rst_idle", 32'(dbg_state), 32'(S_IDLE));
        tick();
        settle();
        check("post_rst_arb", 32'(dbg_state), 32'(S_ARBIT));
        check("post_rst_cnt", 32'(dbg_starve_cnt), 32'd0);

        // ---------------- starvation ordering ----------------
        for (int g = 0; g < 10; g++) begin
            got = 1'b0;
            for (int w = 0; w < 4; w++) begin
                if (!got) begin
                    tick();
                    settle();
                    if (bus.wr_en || bus.rd_en) got = 1'b1;
                end
            end
            check($sformatf("grant_seen_%0d", g), 32'(got), 32'd1);
            if (got) begin
                check($sformatf("grant_who_%0d", g), 32'({bus.wr_en, bus.rd_en}), 32'(exp_grant[g]));
                check($sformatf("grant_cnt_%0d", g), 32'(dbg_starve_cnt), 32'(exp_cnt[g]));
                tick();
                tick();
                bus.wr_end = bus.wr_en;
                bus.rd_end = bus.rd_en;
                tick();
                bus.wr_end = 1'b0;
                bus.rd_end = 1'b0;
                settle();
                check($sformatf("gap_grants_%0d", g), 32'(grants()), 32'd0);
            end
        end

        // ---------------- nothing requested: ARBIT holds ----------------
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        tick();
        settle();
        check("quiet_state", 32'(dbg_state), 32'(S_ARBIT));
        check("quiet_cnt",   32'(dbg_starve_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
